// File: rtl/dmem_pkg.sv
// Shared definitions for the block-granular data memory that sits behind the
// L1 data cache.
//   BLOCK_W       width of one cache block (128 bits)
//   BLOCK_ADDR_W  width of the block address from the cache (byte address >> 4)
//   CNT_W         width of the access-latency down counter
//   dmem_state_t  access FSM states: IDLE -> BUSY -> DONE -> IDLE
package dmem_pkg;

  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Block storage for the data memory: 2**DEPTH_LOG2 entries of BLOCK_W bits.
// The contents are deliberately not reset.
// Ports:
//   CLK         clock, both ports act on posedge
//   write_en    commit write_data to entry write_idx
//   write_idx   write entry index
//   write_data  block to store
//   read_en     load entry read_idx into read_data
//   read_idx    read entry index
//   read_data   registered read block, holds until the next enabled read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  write_en,
  input  logic [DEPTH_LOG2-1:0] write_idx,
  input  logic [BLOCK_W-1:0]    write_data,
  input  logic                  read_en,
  input  logic [DEPTH_LOG2-1:0] read_idx,
  output logic [BLOCK_W-1:0]    read_data
);

  logic [BLOCK_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (write_en) mem[write_idx] <= write_data;
    if (read_en) read_data <= mem[read_idx];
  end

endmodule

// File: rtl/data_memory_block.sv
// Main data memory serving one 128-bit block read or write at a time for the
// L1 data cache, with a fixed LATENCY cycles spent in BUSY per access.
// Optional access statistics are built when DMEM_STATS_EN is defined.
// Ports:
//   CLK             clock, all state updates on posedge
//   RESET           synchronous active-high reset
//   MEM_READ        block read request (level, held until busywait drops)
//   MEM_WRITE       block write request (level); wins over MEM_READ
//   MEM_BLOCK_ADDR  block address; only the low DEPTH_LOG2 bits select an entry
//   MEM_WRITE_OUT   block to be written
//   MEM_READ_OUT    last completed read block (0 after reset)
//   MEM_BUSYWAIT    high while a request is pending or in progress
//   READ_COUNT      (DMEM_STATS_EN) saturating count of completed reads
//   WRITE_COUNT     (DMEM_STATS_EN) saturating count of completed writes
module data_memory_block
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0] MEM_BLOCK_ADDR,
  input  logic [BLOCK_W-1:0]      MEM_WRITE_OUT,
`ifdef DMEM_STATS_EN
  output logic [31:0]             READ_COUNT,
  output logic [31:0]             WRITE_COUNT,
`endif
  output logic [BLOCK_W-1:0]      MEM_READ_OUT,
  output logic                    MEM_BUSYWAIT
);

  localparam logic [CNT_W-1:0] COUNT_START = CNT_W'(LATENCY - 1);

  dmem_state_t           state, next_state;
  logic [CNT_W-1:0]      counter;
  logic                  req;
  logic                  op_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic [BLOCK_W-1:0]    wdata;
  logic                  access_now;
  logic                  array_we;
  logic                  array_re;
  logic                  read_valid;
  logic [BLOCK_W-1:0]    array_rdata;

  // Upper address bits alias onto the same entries and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^MEM_BLOCK_ADDR[BLOCK_ADDR_W-1:DEPTH_LOG2];

  assign req        = MEM_READ | MEM_WRITE;
  assign access_now = (state == BUSY) && (counter == '0);
  // Gating with RESET discards an access that would complete on a reset edge.
  assign array_we   = access_now && op_write && !RESET;
  assign array_re   = access_now && !op_write && !RESET;

  // State register and latency counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) counter <= COUNT_START;
      else if (state == BUSY && counter != '0) counter <= counter - 1'b1;
    end
  end

  // Request latch: captured only when a request is accepted in IDLE, so input
  // changes during BUSY do not affect the access.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      op_write <= MEM_WRITE;
      idx      <= MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
      wdata    <= MEM_WRITE_OUT;
    end
  end

  // read_valid lets the read bus show 0 after reset even though the array's
  // read register itself is not reset.
  always_ff @(posedge CLK) begin
    if (RESET) read_valid <= 1'b0;
    else if (array_re) read_valid <= 1'b1;
  end

  // Next-state and busywait. DONE always returns to IDLE, so a request still
  // held in DONE is only accepted on the following IDLE edge.
  always_comb begin
    next_state   = state;
    MEM_BUSYWAIT = 1'b0;
    case (state)
      IDLE: begin
        MEM_BUSYWAIT = req;
        if (req) next_state = BUSY;
      end
      BUSY: begin
        MEM_BUSYWAIT = 1'b1;
        if (counter == '0) next_state = DONE;
      end
      DONE: begin
        MEM_BUSYWAIT = 1'b0;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign MEM_READ_OUT = read_valid ? array_rdata : '0;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK       (CLK),
    .write_en  (array_we),
    .write_idx (idx),
    .write_data(wdata),
    .read_en   (array_re),
    .read_idx  (idx),
    .read_data (array_rdata)
  );

`ifdef DMEM_STATS_EN
  // Completed-access counters, saturating at all ones.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      READ_COUNT  <= '0;
      WRITE_COUNT <= '0;
    end else begin
      if (array_re && READ_COUNT != 32'hFFFF_FFFF) READ_COUNT <= READ_COUNT + 1'b1;
      if (array_we && WRITE_COUNT != 32'hFFFF_FFFF) WRITE_COUNT <= WRITE_COUNT + 1'b1;
    end
  end
`endif

endmodule
